msu_sector_fetch: RTL

- Upstream stage of the MSU-1 audio sector handler: turns its sector request/seek handshake into a host (HPS) sector read.
- Streams the returned 16-bit words back as download/write strobes bracketed by a sector acknowledge.
- Guarantees every accepted request yields exactly one 1024-byte sector (512 words), zero-padded if the host stalls.
- Sits between the HPS ioctl-style sector port and the audio sector handler.

---
 rtl/msu_pkg.sv | 14 +
 rtl/msu_sector_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/msu_pkg.sv
// Shared constants for the MSU-1 sector path: sector geometry and fetch FSM state codes.
// No logic; imported by the sector fetch stage.
package msu_pkg;

    localparam int SECTOR_WORDS = 512;
    localparam int SECTOR_W     = 22;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_PAD    = 3'd3;
    localparam logic [2:0] ST_END    = 3'd4;

endpackage

// File: rtl/msu_sector_fetch.sv
// Turns an audio sector request/seek into a host sector read and streams exactly WORDS words back.
// Latency 1 cycle host word to strobe; no backpressure, host words are accepted every cycle.
module msu_sector_fetch
    import msu_pkg::*;
#(
    parameter int WORDS       = SECTOR_WORDS,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int TCNT_W      = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                audio_req,
    input  logic                audio_seek,
    input  logic [SECTOR_W-1:0] audio_sector,
    output logic                audio_ack,
    output logic                audio_download,
    output logic                audio_data_wr,
    output logic [15:0]         audio_data,
    output logic                host_req,
    output logic                host_seek,
    output logic [SECTOR_W-1:0] host_sector,
    input  logic                host_ack,
    input  logic                host_wr,
    input  logic [15:0]         host_data,
    output logic                fetch_err
);

    localparam logic [TCNT_W-1:0] TMO_MAX = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [9:0]        WLAST   = 10'(WORDS - 1);

    logic [2:0]        st;
    logic [2:0]        st_nxt;
    logic [9:0]        wcnt;
    logic [TCNT_W-1:0] tcnt;
    logic              seek_q;
    logic              seek_rise;
    logic              abort;
    logic              tmo;
    logic              last_word;

    assign seek_rise = audio_seek & ~seek_q;
    assign abort     = seek_rise & ((st == ST_REQ) | (st == ST_STREAM) | (st == ST_PAD));
    assign tmo       = (tcnt == TMO_MAX);
    assign last_word = (wcnt == WLAST);

    // A seek edge outranks everything else while busy.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:   if (audio_req | audio_seek) st_nxt = ST_REQ;
            ST_REQ: begin
                if (abort)         st_nxt = ST_REQ;
                else if (host_ack) st_nxt = ST_STREAM;
                else if (tmo)      st_nxt = ST_PAD;
            end
            ST_STREAM: begin
                if (abort)                      st_nxt = ST_REQ;
                else if (host_wr && last_word)  st_nxt = ST_END;
                else if (!host_wr && tmo)       st_nxt = ST_PAD;
            end
            ST_PAD: begin
                if (abort)          st_nxt = ST_REQ;
                else if (last_word) st_nxt = ST_END;
            end
            ST_END:    st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    // Host inactivity counter: restarts on any state change or restart, and on each streamed word.
    always_ff @(posedge clk) begin
        if (reset || (st_nxt != st) || abort || ((st == ST_STREAM) && host_wr))
            tcnt <= '0;
        else if (!tmo)
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st             <= ST_IDLE;
            seek_q         <= 1'b0;
            wcnt           <= '0;
            audio_ack      <= 1'b0;
            audio_download <= 1'b0;
            audio_data_wr  <= 1'b0;
            audio_data     <= '0;
            host_req       <= 1'b0;
            host_seek      <= 1'b0;
            host_sector    <= '0;
            fetch_err      <= 1'b0;
        end else begin
            st            <= st_nxt;
            seek_q        <= audio_seek;
            audio_data_wr <= 1'b0;
            if (abort) begin
                host_req       <= 1'b1;
                host_seek      <= 1'b1;
                host_sector    <= audio_sector;
                audio_ack      <= 1'b0;
                audio_download <= 1'b0;
                wcnt           <= '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (audio_req | audio_seek) begin
                            host_req    <= 1'b1;
                            host_seek   <= audio_seek;
                            host_sector <= audio_sector;
                        end
                    end
                    ST_REQ: begin
                        if (host_ack || tmo) begin
                            host_req       <= 1'b0;
                            audio_ack      <= 1'b1;
                            audio_download <= 1'b1;
                            wcnt           <= '0;
                        end
                    end
                    ST_STREAM: begin
                        if (host_wr) begin
                            audio_data_wr <= 1'b1;
                            audio_data    <= host_data;
                            wcnt          <= wcnt + 10'd1;
                        end
                    end
                    ST_PAD: begin
                        audio_data_wr <= 1'b1;
                        audio_data    <= '0;
                        wcnt          <= wcnt + 10'd1;
                        fetch_err     <= 1'b1;
                    end
                    ST_END: begin
                        // Ack drops one cycle after the last strobe so the consumer sees a clean gap.
                        audio_ack      <= 1'b0;
                        audio_download <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
